// File: rtl/i2s_audio_out.sv
// ---------------------------------------------------------------------------
// i2s_audio_out
//
// Serialises a mono signed audio sample from the synth core onto an I2S link
// towards an external DAC. The same sample is sent in the left and in the
// right slot of every frame. A one-deep holding register decouples the
// producer from the frame timing: the producer may hand over the next sample
// at any time during a frame, and it is moved into the transmit register at
// the start of the following frame. If no new sample has arrived by then,
// the previous one is repeated and an underrun pulse is raised.
//
// Ports
//   clk           system clock, the only clock in the block
//   rst_n         asynchronous active-low reset
//   sample_in     signed two's-complement sample (sent as raw bits)
//   sample_valid  sample_in is valid this cycle
//   sample_ready  holding register empty; transfer on valid && ready
//   i2s_bclk      serial bit clock, clk / (2*BCLK_HALF)
//   i2s_lrclk     word select, 0 = left slot, 1 = right slot
//   i2s_data      serial data, MSB first, one BCLK after the slot edge
//   frame_start   one-clk pulse when a new frame begins
//   underrun      one-clk pulse when a frame begins with no fresh sample
// ---------------------------------------------------------------------------
module i2s_audio_out #(
  parameter int SAMPLE_BITS = 12,
  parameter int BCLK_HALF   = 3,
  parameter int SLOT_BITS   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SAMPLE_BITS-1:0] sample_in,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  output logic                   i2s_bclk,
  output logic                   i2s_lrclk,
  output logic                   i2s_data,
  output logic                   frame_start,
  output logic                   underrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(SLOT_BITS);

  logic [DIV_W-1:0]       div_cnt;
  logic [CNT_W-1:0]       bit_cnt;
  logic [SAMPLE_BITS-1:0] hold;
  logic                   hold_full;
  logic [SAMPLE_BITS-1:0] frame_sample;

  logic                   div_wrap;
  logic                   fall_evt;
  logic                   frame_load;
  logic                   accept;
  logic [CNT_W-1:0]       bit_cnt_nxt;
  logic [CNT_W-1:0]       slot_pos;
  logic                   next_lrclk;
  logic                   next_data;

  assign sample_ready = !hold_full;

  // Event decoding and next serial bit. Everything on the link moves on the
  // clk edge where BCLK falls, so the DAC sees stable data on its rising
  // edge. The data bit is selected for the position the bit counter is
  // about to enter: slot position 0 is the I2S delay bit, positions
  // 1..SAMPLE_BITS carry the sample MSB first, the remainder pads with 0.
  always_comb begin
    div_wrap    = (div_cnt == DIV_LAST);
    fall_evt    = div_wrap && i2s_bclk;
    bit_cnt_nxt = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_W'(1);
    frame_load  = fall_evt && (bit_cnt == CNT_LAST);
    accept      = sample_valid && !hold_full;
    next_lrclk  = (bit_cnt_nxt >= SLOT_LEN);
    slot_pos    = next_lrclk ? (bit_cnt_nxt - SLOT_LEN) : bit_cnt_nxt;
    next_data   = 1'b0;
    for (int i = 0; i < SAMPLE_BITS; i++) begin
      if (slot_pos == CNT_W'(SAMPLE_BITS - i)) begin
        next_data = frame_sample[i];
      end
    end
  end

  // BCLK generator: the divider wraps every BCLK_HALF clocks and each wrap
  // toggles the bit clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
    end else if (div_wrap) begin
      div_cnt  <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  // Bit counter, word select and serial data. Reset parks the counter on
  // the last bit of a right slot so that the first BCLK fall after reset
  // opens frame 0 with the left slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= CNT_LAST;
      i2s_lrclk <= 1'b1;
      i2s_data  <= 1'b0;
    end else if (fall_evt) begin
      bit_cnt   <= bit_cnt_nxt;
      i2s_lrclk <= next_lrclk;
      i2s_data  <= next_data;
    end
  end

  // Holding register and frame load. A full holding register blocks the
  // producer, so a waiting sample is never overwritten. At a frame start a
  // waiting sample moves to the transmit register; otherwise the previous
  // sample repeats and underrun is flagged. On an underrun load the hold is
  // empty, so a sample offered on that same edge is still accepted and is
  // played in the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold         <= '0;
      hold_full    <= 1'b0;
      frame_sample <= '0;
      frame_start  <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      frame_start <= frame_load;
      underrun    <= frame_load && !hold_full;
      if (frame_load && hold_full) begin
        frame_sample <= hold;
        hold_full    <= 1'b0;
      end else if (accept) begin
        hold      <= sample_in;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_out.sv
// ---------------------------------------------------------------------------
// tb_i2s_audio_out
//
// Self-checking bench for i2s_audio_out at default parameters. A reference
// model derives the expected link waveform from the number of clocks since
// reset release (BCLK phase, bit index, frame boundaries) plus a one-entry
// sample buffer for the producer handshake. Each scenario task drives its
// own stimulus and compares the DUT outputs inline.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2s_audio_out;

  localparam int SAMPLE_BITS = 12;
  localparam int BCLK_HALF   = 3;
  localparam int SLOT_BITS   = 16;
  localparam int BIT_CLKS    = 2 * BCLK_HALF;
  localparam int FRAME       = 2 * SLOT_BITS * BIT_CLKS;
  localparam int FIRST_FALL  = 2 * BCLK_HALF;

  logic                   clk;
  logic                   rst_n;
  logic [SAMPLE_BITS-1:0] sample_in;
  logic                   sample_valid;
  logic                   sample_ready;
  logic                   i2s_bclk;
  logic                   i2s_lrclk;
  logic                   i2s_data;
  logic                   frame_start;
  logic                   underrun;

  int checks = 0;
  int errors = 0;

  i2s_audio_out #(
    .SAMPLE_BITS(SAMPLE_BITS),
    .BCLK_HALF  (BCLK_HALF),
    .SLOT_BITS  (SLOT_BITS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_data    (i2s_data),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: clocks since reset release, the sample being
  // played and the one waiting for the next frame.
  int                     cyc;
  logic [SAMPLE_BITS-1:0] m_cur;
  logic [SAMPLE_BITS-1:0] m_hold;
  logic                   m_full;
  logic                   exp_start;
  logic                   exp_under;

  function automatic bit is_load(input int c);
    return (c >= FIRST_FALL) && (((c - FIRST_FALL) % FRAME) == 0);
  endfunction

  function automatic int exp_bitc();
    if (cyc < FIRST_FALL) return 2 * SLOT_BITS - 1;
    return ((cyc - FIRST_FALL) / BIT_CLKS) % (2 * SLOT_BITS);
  endfunction

  function automatic logic exp_bclk();
    return ((cyc / BCLK_HALF) % 2) == 1;
  endfunction

  function automatic logic exp_lrclk();
    return exp_bitc() >= SLOT_BITS;
  endfunction

  function automatic logic exp_data();
    int p;
    p = exp_bitc() % SLOT_BITS;
    if (p >= 1 && p <= SAMPLE_BITS) return m_cur[SAMPLE_BITS - p];
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc       <= 0;
      m_cur     <= '0;
      m_hold    <= '0;
      m_full    <= 1'b0;
      exp_start <= 1'b0;
      exp_under <= 1'b0;
    end else begin
      cyc       <= cyc + 1;
      exp_start <= is_load(cyc + 1);
      exp_under <= is_load(cyc + 1) && !m_full;
      if (is_load(cyc + 1) && m_full) begin
        m_cur  <= m_hold;
        m_full <= 1'b0;
      end else if (sample_valid && !m_full) begin
        m_hold <= sample_in;
        m_full <= 1'b1;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target && guard < 4 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != target) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_cyc got=%0d exp=%0d", cyc, target);
    end
  endtask

  // Collects the sample bits (positions 1..SAMPLE_BITS) of one slot.
  task automatic capture_word(input int frame, input int slot,
                              output logic [SAMPLE_BITS-1:0] w);
    w = '0;
    for (int p = 1; p <= SAMPLE_BITS; p++) begin
      wait_cyc(FIRST_FALL + frame * FRAME + BIT_CLKS * (slot * SLOT_BITS + p));
      w[SAMPLE_BITS - p] = i2s_data;
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(10);
    #2 rst_n = 1'b0;
    for (int r = 0; r < 2; r++) begin
      if (r == 0) #1;
      else repeat (2) @(negedge clk);
      checks += 6;
      if (i2s_bclk !== 1'b0) begin errors++; $display("[TB] FAIL reset_bclk got=%b exp=0", i2s_bclk); end
      if (i2s_lrclk !== 1'b1) begin errors++; $display("[TB] FAIL reset_lrclk got=%b exp=1", i2s_lrclk); end
      if (i2s_data !== 1'b0) begin errors++; $display("[TB] FAIL reset_data got=%b exp=0", i2s_data); end
      if (sample_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", sample_ready); end
      if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_start got=%b exp=0", frame_start); end
      if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_underrun got=%b exp=0", underrun); end
    end
  endtask

  task automatic test_idle();
    logic exp_b, exp_f;
    do_reset();
    for (int i = 1; i <= FRAME + 8; i++) begin
      @(negedge clk);
      exp_b = (i < 3) ? 1'b0 : ((i == 3) ? 1'b1 : exp_bclk());
      exp_f = (i == 6) || (i == 6 + FRAME);
      checks += 5;
      if (i2s_bclk !== exp_b) begin errors++; $display("[TB] FAIL idle_bclk cyc=%0d got=%b exp=%b", cyc, i2s_bclk, exp_b); end
      if (frame_start !== exp_f) begin errors++; $display("[TB] FAIL idle_frame_start cyc=%0d got=%b exp=%b", cyc, frame_start, exp_f); end
      if (underrun !== exp_f) begin errors++; $display("[TB] FAIL idle_underrun cyc=%0d got=%b exp=%b", cyc, underrun, exp_f); end
      if (i2s_data !== 1'b0) begin errors++; $display("[TB] FAIL idle_data cyc=%0d got=%b exp=0", cyc, i2s_data); end
      if (sample_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_ready cyc=%0d got=%b exp=1", cyc, sample_ready); end
    end
  endtask

  task automatic test_pattern();
    logic [15:0] pat;
    int          p;
    pat = 16'b0101_0010_1110_0000;
    do_reset();
    sample_valid = 1'b1;
    sample_in    = 12'hA5C;
    @(negedge clk);
    sample_valid = 1'b0;
    for (int k = 0; k < 2 * SLOT_BITS; k++) begin
      wait_cyc(FIRST_FALL + k * BIT_CLKS);
      p = k % SLOT_BITS;
      checks += 2;
      if (i2s_data !== pat[15 - p]) begin errors++; $display("[TB] FAIL pattern_data bit=%0d got=%b exp=%b", k, i2s_data, pat[15 - p]); end
      if (i2s_lrclk !== (k >= SLOT_BITS)) begin errors++; $display("[TB] FAIL pattern_lrclk bit=%0d got=%b exp=%b", k, i2s_lrclk, (k >= SLOT_BITS)); end
    end
  endtask

  task automatic test_streaming();
    int   last_start = -1;
    int   n_acc = 0;
    int   n_frames = 0;
    logic prev_ready;
    do_reset();
    sample_valid = 1'b1;
    while (n_frames < 4 && cyc < 5 * FRAME) begin
      prev_ready = sample_ready;
      sample_in  = SAMPLE_BITS'($urandom_range(0, 4095));
      @(negedge clk);
      if (prev_ready) n_acc++;
      checks += 4;
      if (sample_ready !== !m_full) begin errors++; $display("[TB] FAIL stream_ready cyc=%0d got=%b exp=%b", cyc, sample_ready, !m_full); end
      if (frame_start !== exp_start) begin errors++; $display("[TB] FAIL stream_frame_start cyc=%0d got=%b exp=%b", cyc, frame_start, exp_start); end
      if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL stream_underrun cyc=%0d got=%b exp=0", cyc, underrun); end
      if (i2s_data !== exp_data()) begin errors++; $display("[TB] FAIL stream_data cyc=%0d got=%b exp=%b", cyc, i2s_data, exp_data()); end
      if (frame_start) begin
        checks++;
        if (sample_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_ready_after_start cyc=%0d got=%b exp=1", cyc, sample_ready); end
        if (last_start >= 0) begin
          checks += 2;
          if (cyc - last_start != FRAME) begin errors++; $display("[TB] FAIL stream_spacing got=%0d exp=%0d", cyc - last_start, FRAME); end
          if (n_acc != 1) begin errors++; $display("[TB] FAIL stream_accepts_per_frame got=%0d exp=1", n_acc); end
        end
        last_start = cyc;
        n_acc      = 0;
        n_frames++;
      end
    end
    sample_valid = 1'b0;
    checks++;
    if (n_frames != 4) begin errors++; $display("[TB] FAIL stream_frames got=%0d exp=4", n_frames); end
  endtask

  task automatic test_no_overrun();
    logic [SAMPLE_BITS-1:0] w;
    do_reset();
    sample_valid = 1'b1;
    sample_in    = 12'h3C7;
    @(negedge clk);
    sample_in = 12'h123;
    while (cyc < 5) begin
      checks++;
      if (sample_ready !== 1'b0) begin errors++; $display("[TB] FAIL overrun_ready cyc=%0d got=%b exp=0", cyc, sample_ready); end
      @(negedge clk);
    end
    sample_valid = 1'b0;
    capture_word(0, 0, w);
    checks++;
    if (w !== 12'h3C7) begin errors++; $display("[TB] FAIL overrun_left got=%h exp=3c7", w); end
    capture_word(0, 1, w);
    checks++;
    if (w !== 12'h3C7) begin errors++; $display("[TB] FAIL overrun_right got=%h exp=3c7", w); end
    wait_cyc(FIRST_FALL + FRAME);
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_frame1_underrun got=%b exp=1", underrun); end
    capture_word(1, 0, w);
    checks++;
    if (w !== 12'h3C7) begin errors++; $display("[TB] FAIL overrun_repeat got=%h exp=3c7", w); end
  endtask

  task automatic test_underrun_accept();
    logic [SAMPLE_BITS-1:0] w;
    do_reset();
    sample_valid = 1'b1;
    sample_in    = 12'h5A3;
    @(negedge clk);
    sample_valid = 1'b0;
    wait_cyc(FIRST_FALL + FRAME - 1);
    sample_valid = 1'b1;
    sample_in    = 12'h800;
    @(negedge clk);
    sample_valid = 1'b0;
    checks += 3;
    if (frame_start !== 1'b1) begin errors++; $display("[TB] FAIL ua_frame_start got=%b exp=1", frame_start); end
    if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL ua_underrun got=%b exp=1", underrun); end
    if (sample_ready !== 1'b0) begin errors++; $display("[TB] FAIL ua_ready got=%b exp=0", sample_ready); end
    capture_word(1, 0, w);
    checks++;
    if (w !== 12'h5A3) begin errors++; $display("[TB] FAIL ua_current_frame got=%h exp=5a3", w); end
    wait_cyc(FIRST_FALL + 2 * FRAME);
    checks += 2;
    if (frame_start !== 1'b1) begin errors++; $display("[TB] FAIL ua_next_start got=%b exp=1", frame_start); end
    if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL ua_next_underrun got=%b exp=0", underrun); end
    capture_word(2, 0, w);
    checks++;
    if (w !== 12'h800) begin errors++; $display("[TB] FAIL ua_next_left got=%h exp=800", w); end
    capture_word(2, 1, w);
    checks++;
    if (w !== 12'h800) begin errors++; $display("[TB] FAIL ua_next_right got=%h exp=800", w); end
  endtask

  task automatic test_reset_midframe();
    logic [SAMPLE_BITS-1:0] w;
    do_reset();
    sample_valid = 1'b1;
    sample_in    = 12'h7FF;
    @(negedge clk);
    sample_valid = 1'b0;
    wait_cyc(FIRST_FALL + 1);
    sample_valid = 1'b1;
    sample_in    = 12'h456;
    @(negedge clk);
    sample_valid = 1'b0;
    wait_cyc(FIRST_FALL + 20 * BIT_CLKS);
    checks += 2;
    if (sample_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_pre_ready got=%b exp=0", sample_ready); end
    if (i2s_data !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_data got=%b exp=1", i2s_data); end
    #2 rst_n = 1'b0;
    #1;
    checks += 6;
    if (i2s_bclk !== 1'b0) begin errors++; $display("[TB] FAIL mid_bclk got=%b exp=0", i2s_bclk); end
    if (i2s_lrclk !== 1'b1) begin errors++; $display("[TB] FAIL mid_lrclk got=%b exp=1", i2s_lrclk); end
    if (i2s_data !== 1'b0) begin errors++; $display("[TB] FAIL mid_data got=%b exp=0", i2s_data); end
    if (sample_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready got=%b exp=1", sample_ready); end
    if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL mid_frame_start got=%b exp=0", frame_start); end
    if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL mid_underrun got=%b exp=0", underrun); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(FIRST_FALL);
    checks += 2;
    if (frame_start !== 1'b1) begin errors++; $display("[TB] FAIL mid_after_start got=%b exp=1", frame_start); end
    if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL mid_after_underrun got=%b exp=1", underrun); end
    capture_word(0, 0, w);
    checks++;
    if (w !== 12'h000) begin errors++; $display("[TB] FAIL mid_after_word got=%h exp=000", w); end
  endtask

  task automatic test_random();
    int thresh = 0;
    do_reset();
    for (int i = 0; i < 5 * FRAME; i++) begin
      if (i % FRAME == 0) begin
        case ($urandom_range(0, 3))
          0:       thresh = 0;
          1:       thresh = 2;
          2:       thresh = 16;
          default: thresh = 256;
        endcase
      end
      sample_valid = ($urandom_range(0, 255) < thresh);
      sample_in    = SAMPLE_BITS'($urandom_range(0, 4095));
      @(negedge clk);
      checks += 6;
      if (i2s_bclk !== exp_bclk()) begin errors++; $display("[TB] FAIL rand_bclk cyc=%0d got=%b exp=%b", cyc, i2s_bclk, exp_bclk()); end
      if (i2s_lrclk !== exp_lrclk()) begin errors++; $display("[TB] FAIL rand_lrclk cyc=%0d got=%b exp=%b", cyc, i2s_lrclk, exp_lrclk()); end
      if (i2s_data !== exp_data()) begin errors++; $display("[TB] FAIL rand_data cyc=%0d got=%b exp=%b", cyc, i2s_data, exp_data()); end
      if (sample_ready !== !m_full) begin errors++; $display("[TB] FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, sample_ready, !m_full); end
      if (frame_start !== exp_start) begin errors++; $display("[TB] FAIL rand_frame_start cyc=%0d got=%b exp=%b", cyc, frame_start, exp_start); end
      if (underrun !== exp_under) begin errors++; $display("[TB] FAIL rand_underrun cyc=%0d got=%b exp=%b", cyc, underrun, exp_under); end
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    $display("[TB] starting i2s_audio_out bench");
    test_reset();
    test_idle();
    test_pattern();
    test_streaming();
    test_no_overrun();
    test_underrun_accept();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_audio_out.md
I2S_AUDIO_OUT -- requirements
Module: i2s_audio_out

Interface
REQ-001 Parameter SAMPLE_BITS, default 12, width of the signed mixed/filtered sample accepted from the synth core.
REQ-002 Parameter BCLK_HALF, default 3, clk cycles per half BCLK period; legal range >= 1.
REQ-003 Parameter SLOT_BITS, default 16, BCLK periods per channel slot; legal range >= SAMPLE_BITS+1.
REQ-004 clk  input  1  system clock (16 MHz), the only clock in the block.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 sample_in  input  SAMPLE_BITS  signed two's-complement audio sample.
REQ-007 sample_valid  input  1  sample_in is valid this cycle.
REQ-008 sample_ready  output  1  holding register empty; a sample is accepted when valid and ready are both high.
REQ-009 i2s_bclk  output  1  serial bit clock to DAC.
REQ-010 i2s_lrclk  output  1  word select; 0 = left slot, 1 = right slot.
REQ-011 i2s_data  output  1  serial data, MSB first, I2S one-BCLK delay.
REQ-012 frame_start  output  1  one-clk pulse when a new frame sample is loaded.
REQ-013 underrun  output  1  one-clk pulse when a frame starts with the holding register empty.

Function
REQ-014 A divider counter shall count 0..BCLK_HALF-1; on wrap, i2s_bclk toggles, giving BCLK = clk/(2*BCLK_HALF).
REQ-015 A falling-edge event is a divider wrap while i2s_bclk=1; all bit-counter, lrclk, data and frame-load updates happen only on that clk edge, so they change together with BCLK falling.
REQ-016 Bit counter bit_cnt shall run 0..2*SLOT_BITS-1 and wrap to 0; frame period = 4*SLOT_BITS*BCLK_HALF clk cycles (192 at defaults).
REQ-017 i2s_lrclk shall be 0 while bit_cnt < SLOT_BITS, else 1.
REQ-018 Within each slot, at slot position p = bit_cnt mod SLOT_BITS: p=0 drives 0; p=1..SAMPLE_BITS drives frame_sample[SAMPLE_BITS-p]; p > SAMPLE_BITS drives 0.
REQ-019 Mono output: the same frame_sample is transmitted in the left and right slots.
REQ-020 Handshake: sample_ready = !hold_full; on valid&&ready, hold <= sample_in and hold_full <= 1 at that clk edge.
REQ-021 Frame load, on the falling-edge event that sets bit_cnt to 0: if hold_full, frame_sample <= hold, hold_full <= 0 and frame_start pulses.
REQ-022 Frame load with hold_full=0: frame_sample is retained (previous sample repeats), and frame_start and underrun both pulse.
REQ-023 A sample accepted on the same clk edge as an underrun frame load shall go to hold and is played in the next frame, not the current one.
REQ-024 While hold_full=1, sample_valid is ignored; the sample in hold is never overwritten (no silent overrun).
REQ-025 Signed samples shall be serialized as raw two's-complement bits; there is no sign extension or scaling.

Reset
REQ-026 While rst_n=0: i2s_bclk=0, i2s_lrclk=1, i2s_data=0, divider=0, bit_cnt=2*SLOT_BITS-1, hold_full=0 (so sample_ready=1), frame_sample=0, frame_start=0, underrun=0.
REQ-027 After rst_n deasserts, the first falling-edge event starts frame 0 (bit_cnt=0); a reset asserted mid-frame aborts the frame immediately and discards hold.

Verification
REQ-028 Default parameters; reset release; no samples -> first bclk rise at the 3rd clk; first frame_start+underrun at clk 6; i2s_data constant 0.
REQ-029 Present 12'hA5C before frame 0 -> left and right slots each carry p0..15 = 0,1,0,1,0,0,1,0,1,1,1,0,0,0,0,0; lrclk low for 16 BCLKs then high for 16.
REQ-030 Hold sample_valid high with a new value continuously -> exactly one acceptance per frame (sample_ready high for one clk after each frame_start); 192-clk frame spacing.
REQ-031 Hold full while valid is asserted with 12'h123 -> hold keeps the earlier value; the earlier value is played, not 12'h123.
REQ-032 Accept 12'h800 on the exact clk of an underrun load -> current frame repeats the old sample; next frame transmits 1,0,0,0,0,0,0,0,0,0,0,0 at p1..12.
REQ-033 Assert rst_n=0 at bit_cnt=20 with hold full -> all outputs return to REQ-026 values asynchronously; after release, frame 0 underruns.
